// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// pc_unit : program counter with sequential/jump/branch/call/return selection
//           and a hardware return-address stack with sticky over/underflow.
// Revision: 1.0
// ============================================================================
module pc_unit #(
  parameter int ADDR_W      = 9,
  parameter int OFF_W       = 6,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [2:0]                           op,
  input  logic [ADDR_W-1:0]                    target,
  input  logic [OFF_W-1:0]                     offset,
  input  logic                                 cond,
  input  logic                                 err_clr,
  output logic [ADDR_W-1:0]                    pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
  output logic                                 stack_full,
  output logic                                 stack_empty,
  output logic                                 ovf_err,
  output logic                                 unf_err
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_branch;
  logic               full;
  logic               empty;

  assign full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  always_comb begin
    pc_inc    = pc_q + ADDR_W'(1);
    // Size cast of a signed operand sign-extends, so wrap works both ways.
    pc_branch = pc_q + ADDR_W'($signed(offset));
    pc_d      = pc_q;
    depth_d   = depth_q;
    stack_d   = stack_q;
    ovf_d     = ovf_q & ~err_clr;
    unf_d     = unf_q & ~err_clr;

    if (enable) begin
      case (op)
        OP_NEXT:   pc_d = pc_inc;
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = cond ? pc_branch : pc_inc;
        OP_CALL: begin
          if (full) begin
            pc_d  = pc_inc;
            ovf_d = 1'b1;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (depth_q == DEPTH_W'(i)) stack_d[i] = pc_inc;
            end
            depth_d = depth_q + DEPTH_W'(1);
            pc_d    = target;
          end
        end
        OP_RET: begin
          if (empty) begin
            pc_d  = pc_inc;
            unf_d = 1'b1;
          end else begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
              if (depth_q == DEPTH_W'(i + 1)) pc_d = stack_q[i];
            end
            depth_d = depth_q - DEPTH_W'(1);
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack contents are meaningless once depth is cleared, so no reset here.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc          = pc_q;
  assign depth       = depth_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_unit : randomized + directed bench with queue-based reference model
//              and decoupled scoreboard monitor.
// Revision: 1.0
// ============================================================================
module tb_pc_unit;

  localparam int ADDR_W = 9;
  localparam int OFF_W  = 6;
  localparam int SD     = 4;
  localparam int DW     = $clog2(SD + 1);
  localparam int M      = 1 << ADDR_W;
  localparam int RV     = 0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [2:0]        op = 3'd0;
  logic [ADDR_W-1:0] target = '0;
  logic [OFF_W-1:0]  offset = '0;
  logic              cond = 1'b0;
  logic              err_clr = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic [DW-1:0]     depth;
  logic              stack_full, stack_empty, ovf_err, unf_err;

  pc_unit #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .STACK_DEPTH(SD),
            .RESET_VEC(ADDR_W'(RV))) dut (
    .clk(clk), .rst(rst), .enable(enable), .op(op), .target(target),
    .offset(offset), .cond(cond), .err_clr(err_clr), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int depth;
    bit full;
    bit empty;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_pc = RV;
  int   m_stack[$];
  bit   m_ovf = 0;
  bit   m_unf = 0;

  function automatic int wrap(input int x);
    return ((x % M) + M) % M;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies one cycle of architectural behaviour.
  task automatic model(input bit r, input bit e, input int o, input int t,
                       input int f, input bit c, input bit k);
    int soff;
    soff = (f >= (1 << (OFF_W - 1))) ? f - (1 << OFF_W) : f;
    if (r) begin
      m_pc = RV;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (k) begin
        m_ovf = 0;
        m_unf = 0;
      end
      if (e) begin
        case (o)
          0: m_pc = wrap(m_pc + 1);
          1: m_pc = t;
          2: m_pc = c ? wrap(m_pc + soff) : wrap(m_pc + 1);
          3: if (m_stack.size() == SD) begin
               m_pc = wrap(m_pc + 1);
               m_ovf = 1;
             end else begin
               m_stack.push_back(wrap(m_pc + 1));
               m_pc = t;
             end
          4: if (m_stack.size() == 0) begin
               m_pc = wrap(m_pc + 1);
               m_unf = 1;
             end else begin
               m_pc = m_stack.pop_back();
             end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input int o, input int t,
                      input int f, input bit c, input bit k);
    exp_t x;
    @(negedge clk);
    rst     = r;
    enable  = e;
    op      = 3'(o);
    target  = ADDR_W'(t);
    offset  = OFF_W'(f);
    cond    = c;
    err_clr = k;
    model(r, e, o, t, f, c, k);
    x.pc    = m_pc;
    x.depth = m_stack.size();
    x.full  = (m_stack.size() == SD);
    x.empty = (m_stack.size() == 0);
    x.ovf   = m_ovf;
    x.unf   = m_unf;
    exp_q.push_back(x);
  endtask

  // Monitor: every edge produces a registered state to compare.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("pc", int'(pc), x.pc);
        check("depth", int'(depth), x.depth);
        check("stack_full", int'(stack_full), int'(x.full));
        check("stack_empty", int'(stack_empty), int'(x.empty));
        check("ovf_err", int'(ovf_err), int'(x.ovf));
        check("unf_err", int'(unf_err), int'(x.unf));
      end
    end
  end

  initial begin
    // Reset and stall
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 77, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // Wrap and branch
    step(0, 1, 1, 511, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 10, 0, 0, 0);
    step(0, 1, 2, 0, 61, 1, 0);   // -3
    step(0, 1, 2, 0, 5, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 2, 0, 62, 1, 0);   // -2
    step(0, 1, 2, 0, 31, 1, 0);   // max positive offset
    // Nested calls
    step(0, 1, 1, 20, 0, 0, 0);
    step(0, 1, 3, 100, 0, 0, 0);
    step(0, 1, 3, 200, 0, 0, 0);
    step(0, 1, 3, 300, 0, 0, 0);
    repeat (3) step(0, 1, 4, 0, 0, 0, 0);
    // Overflow, persistence, clear; stall during clear still clears
    step(0, 1, 1, 511, 0, 0, 0);
    for (int i = 0; i < SD; i++) step(0, 1, 3, 40 + i, 0, 0, 0);
    step(0, 1, 3, 50, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (SD) step(0, 1, 4, 0, 0, 0, 0);
    // Underflow and set-over-clear priority
    step(0, 1, 1, 30, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0, 1);
    step(0, 1, 5, 0, 0, 0, 1);
    step(0, 1, 6, 0, 0, 0, 0);
    // Reset mid-sequence
    step(0, 1, 3, 123, 0, 0, 0);
    step(0, 1, 3, 222, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0);
    step(0, 1, 4, 0, 0, 0, 0);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 9) < 8),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, (1 << OFF_W) - 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end
    @(posedge clk);
    #3;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
